fifo_drain_ctrl: RTL and testbench

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_out_skid.sv | 50 +++++
 rtl/fifo_drain_ctrl.sv | 68 ++++++
 tb/tb_fifo_drain_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO drain path: data width default, FIFO status bit
// indices and the output buffer depth.
package fifo_pkg;

    localparam int unsigned DATA_SIZE_DEF = 8;
    localparam int unsigned ST_FULL       = 0;
    localparam int unsigned ST_EMPTY      = 1;
    localparam int unsigned OUT_BUF_DEPTH = 3;

    typedef logic [1:0] occ_t;

    // Pointer advance over OUT_BUF_DEPTH entries (non power-of-two).
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(OUT_BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// In-order output buffer of OUT_BUF_DEPTH entries with push, pop, occupancy and
// head-of-queue data. The caller guarantees push is never issued into a full buffer.
module fifo_out_skid
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output occ_t                 occ,
    output logic [DATA_SIZE-1:0] head_data
);

    logic [DATA_SIZE-1:0] r_mem [OUT_BUF_DEPTH];
    logic [1:0]           r_rd_ptr;
    logic [1:0]           r_wr_ptr;
    occ_t                 r_occ;

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(OUT_BUF_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= 2'd0;
            r_wr_ptr <= 2'd0;
            r_occ    <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign occ       = r_occ;
    assign head_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains a synchronous-read FIFO into a valid/ready stream: issues reads only when
// the output buffer has room for the word plus any word already in flight.
module fifo_drain_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 fifo_empty,
    output logic                 fifo_re,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic [DATA_SIZE-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [CNT_W-1:0]     drain_count,
    output logic                 busy
);

    logic             r_started;
    logic             r_infl;
    logic [CNT_W-1:0] r_cnt;
    occ_t             w_occ;
    logic [2:0]       w_level;
    logic             w_re;
    logic             w_valid;
    logic             w_xfer;

    // r_started holds off reads until the first edge after reset release.
    assign w_level = {1'b0, w_occ} + {2'b00, r_infl};
    assign w_re    = r_started & enable & ~fifo_empty & (w_level < 3'(OUT_BUF_DEPTH));
    assign w_valid = (w_occ != 2'd0);
    assign w_xfer  = w_valid & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started <= 1'b0;
            r_infl    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_started <= 1'b1;
            r_infl    <= w_re;
            if (w_xfer) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    fifo_out_skid #(
        .DATA_SIZE(DATA_SIZE)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (r_infl),
        .push_data(fifo_data),
        .pop      (w_xfer),
        .occ      (w_occ),
        .head_data(m_data)
    );

    assign fifo_re     = w_re;
    assign m_valid     = w_valid;
    assign drain_count = r_cnt;
    assign busy        = w_valid | r_infl;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl against a one-cycle-latency FIFO model;
// built with CNT_W = 4 so counter wrap is reachable.
module tb_fifo_drain_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       fifo_empty;
    logic       fifo_re;
    logic [7:0] fifo_data = 8'h00;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] drain_count;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mdl_mem [0:127];
    int         fq_pushed = 0;
    int         fq_popped = 0;
    int         re_cnt = 0;
    int         re_empty_err = 0;

    logic [7:0] got [0:31];
    int         nx;

    fifo_drain_ctrl #(
        .DATA_SIZE(8),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_re    (fifo_re),
        .fifo_data  (fifo_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .drain_count(drain_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (fq_pushed == fq_popped);

    // FIFO model: data appears on fifo_data the cycle after fifo_re is sampled.
    always @(posedge clk) begin
        if (fifo_re) begin
            re_cnt <= re_cnt + 1;
            if (fq_pushed == fq_popped) begin
                re_empty_err <= re_empty_err + 1;
            end else begin
                fifo_data <= mdl_mem[fq_popped];
                fq_popped <= fq_popped + 1;
            end
        end
    end

    task automatic preload(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            mdl_mem[fq_pushed] = base + 8'(i);
            fq_pushed++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b0;
        fq_pushed = fq_popped;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        preload(2, 8'hA1);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_checks++; if (fifo_re !== 1'b0) begin n_errors++; $display("FAIL reset_fifo_re: got %b want 0", fifo_re); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (drain_count !== 4'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", drain_count); end
        n_checks++; if (m_data !== 8'h00) begin n_errors++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (fifo_re !== 1'b0) begin n_errors++; $display("FAIL release_re_early: got %b want 0", fifo_re); end
        @(negedge clk);
        #1;
        n_checks++; if (fifo_re !== 1'b1) begin n_errors++; $display("FAIL release_re_first_edge: got %b want 1", fifo_re); end
    endtask

    task automatic test_stream();
        int re0;
        int er0;
        apply_reset();
        preload(8, 8'h01);
        re0 = re_cnt;
        er0 = re_empty_err;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            enable  = 1'b1;
            m_ready = 1'b1;
            #1;
            n_checks++;
            if (fifo_re !== (c < 8)) begin n_errors++; $display("FAIL stream_re c=%0d: got %b want %b", c, fifo_re, c < 8); end
            n_checks++;
            if (m_valid !== (c >= 2 && c <= 9)) begin
                n_errors++; $display("FAIL stream_valid c=%0d: got %b want %b", c, m_valid, c >= 2 && c <= 9);
            end
            if (c >= 2 && c <= 9) begin
                n_checks++;
                if (m_data !== 8'(c - 1)) begin n_errors++; $display("FAIL stream_data c=%0d: got %h want %h", c, m_data, 8'(c - 1)); end
            end
        end
        n_checks++; if (drain_count !== 4'd8) begin n_errors++; $display("FAIL stream_count: got %0d want 8", drain_count); end
        n_checks++; if (re_cnt - re0 != 8) begin n_errors++; $display("FAIL stream_reads: got %0d want 8", re_cnt - re0); end
        n_checks++; if (re_empty_err != er0) begin n_errors++; $display("FAIL stream_re_on_empty: got %0d want %0d", re_empty_err, er0); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL stream_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int re0;
        int nre;
        apply_reset();
        preload(5, 8'h01);
        re0 = re_cnt;
        nre = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            enable  = 1'b1;
            m_ready = 1'b0;
            #1;
            if (fifo_re === 1'b1) nre++;
        end
        n_checks++; if (nre != 3) begin n_errors++; $display("FAIL bp_re_cycles: got %0d want 3", nre); end
        n_checks++; if (re_cnt - re0 != 3) begin n_errors++; $display("FAIL bp_reads: got %0d want 3", re_cnt - re0); end
        n_checks++; if (m_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid_held: got %b want 1", m_valid); end
        n_checks++; if (m_data !== 8'h01) begin n_errors++; $display("FAIL bp_data_held: got %h want 01", m_data); end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            m_ready = 1'b1;
            #1;
            n_checks++;
            if (m_valid !== (c < 5)) begin n_errors++; $display("FAIL bp_valid c=%0d: got %b want %b", c, m_valid, c < 5); end
            if (c < 5) begin
                n_checks++;
                if (m_data !== 8'(c + 1)) begin n_errors++; $display("FAIL bp_data c=%0d: got %h want %h", c, m_data, 8'(c + 1)); end
            end
        end
        n_checks++; if (drain_count !== 4'd5) begin n_errors++; $display("FAIL bp_count: got %0d want 5", drain_count); end
    endtask

    task automatic test_toggle();
        apply_reset();
        preload(6, 8'h21);
        nx = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            enable  = 1'b1;
            m_ready = (c % 2 == 1);
            #1;
            if (m_valid === 1'b1 && m_ready && nx < 32) begin
                got[nx] = m_data;
                nx++;
            end
        end
        n_checks++; if (nx != 6) begin n_errors++; $display("FAIL toggle_xfers: got %0d want 6", nx); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got[i] !== 8'h21 + 8'(i)) begin n_errors++; $display("FAIL toggle_data i=%0d: got %h want %h", i, got[i], 8'h21 + 8'(i)); end
        end
        n_checks++; if (drain_count !== 4'd6) begin n_errors++; $display("FAIL toggle_count: got %0d want 6", drain_count); end
    endtask

    task automatic test_enable_drop();
        int re0;
        apply_reset();
        preload(5, 8'h41);
        re0 = re_cnt;
        nx = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            // enable is seen high for the first read and the one after it
            enable  = (c < 2);
            m_ready = 1'b1;
            #1;
            if (c == 1) begin
                n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL en_busy_inflight: got %b want 1", busy); end
            end
            if (c == 3) begin
                n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL en_busy_last: got %b want 1", busy); end
            end
            if (c == 4) begin
                n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL en_busy_fall: got %b want 0", busy); end
            end
            if (m_valid === 1'b1 && nx < 32) begin
                got[nx] = m_data;
                nx++;
            end
        end
        n_checks++; if (re_cnt - re0 != 2) begin n_errors++; $display("FAIL en_reads: got %0d want 2", re_cnt - re0); end
        n_checks++; if (nx != 2) begin n_errors++; $display("FAIL en_xfers: got %0d want 2", nx); end
        n_checks++; if (got[0] !== 8'h41) begin n_errors++; $display("FAIL en_data0: got %h want 41", got[0]); end
        n_checks++; if (got[1] !== 8'h42) begin n_errors++; $display("FAIL en_data1: got %h want 42", got[1]); end
        n_checks++; if (drain_count !== 4'd2) begin n_errors++; $display("FAIL en_count: got %0d want 2", drain_count); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        preload(6, 8'h61);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            enable  = 1'b1;
            m_ready = 1'b0;
            #1;
        end
        // two words buffered, third in flight, buffer full so no read this cycle
        n_checks++; if (m_valid !== 1'b1) begin n_errors++; $display("FAIL mid_pre_valid: got %b want 1", m_valid); end
        n_checks++; if (fifo_re !== 1'b0) begin n_errors++; $display("FAIL mid_pre_re: got %b want 0", fifo_re); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL mid_valid: got %b want 0", m_valid); end
        n_checks++; if (fifo_re !== 1'b0) begin n_errors++; $display("FAIL mid_re: got %b want 0", fifo_re); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_checks++; if (drain_count !== 4'd0) begin n_errors++; $display("FAIL mid_count: got %0d want 0", drain_count); end
        n_checks++; if (m_data !== 8'h00) begin n_errors++; $display("FAIL mid_data: got %h want 00", m_data); end
        @(negedge clk);
        fq_pushed = fq_popped;
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (m_valid !== 1'b0 || busy !== 1'b0) begin
                n_errors++; $display("FAIL mid_stale c=%0d: valid %b busy %b want 0 0", c, m_valid, busy);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        preload(17, 8'h80);
        nx = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            enable  = 1'b1;
            m_ready = 1'b1;
            #1;
            if (m_valid === 1'b1) nx++;
        end
        n_checks++; if (nx != 17) begin n_errors++; $display("FAIL wrap_xfers: got %0d want 17", nx); end
        n_checks++; if (drain_count !== 4'd1) begin n_errors++; $display("FAIL wrap_count: got %0d want 1", drain_count); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL wrap_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
